// File: rtl/mips_boot_pkg.sv
// Shared definitions for the MIPS boot loader: loader states and word geometry.
package mips_boot_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    FLUSH,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/boot_byte_packer.sv
// Packs accepted host bytes into little-endian words; word_valid pulses with the
// completing byte so the parent can register the write on that same edge.
module boot_byte_packer
  import mips_boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [7:0]        rx_byte,
  input  logic              accept,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int             IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-9:0] low;

  // The top byte is never stored: it arrives on the completing edge itself.
  always_comb begin
    word_valid = accept && (idx == LAST);
    word       = {rx_byte, low};
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx <= '0;
      low <= '0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      if (idx != LAST) begin
        low[{idx, 3'b000} +: 8] <= rx_byte;
      end
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: receives a length header and payload bytes, writes instruction
// memory, then releases the MIPS core from reset once every word is written.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   n_words;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              accept;
  logic              restart;
  logic [ADDR_W:0]   hdr_n;
  logic              hdr_bad;

  assign rx_ready = (state == HDR) || (state == LOAD);
  assign busy     = (state == HDR) || (state == LOAD) || (state == FLUSH);
  assign accept   = rx_valid && rx_ready;
  assign restart  = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  // Header carries the word count in its low bits; anything above must be zero.
  assign hdr_n   = word[ADDR_W:0];
  assign hdr_bad = (hdr_n == '0) || (hdr_n > CAPACITY) || ((word >> (ADDR_W + 1)) != '0);

  boot_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .rx_byte    (rx_data),
    .accept     (accept),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      n_words      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: if (start) state <= HDR;
        HDR: begin
          if (word_valid) begin
            if (hdr_bad) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              n_words <= hdr_n;
              state   <= LOAD;
            end
          end
        end
        LOAD: begin
          // The count before incrementing is the address of the word just completed.
          if (word_valid) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= word;
            words_loaded <= words_loaded + 1'b1;
            if (words_loaded + 1'b1 == n_words) state <= FLUSH;
          end
        end
        FLUSH: begin
          state      <= DONE;
          done       <= 1'b1;
          core_reset <= 1'b1;
        end
        DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            done         <= 1'b0;
            error        <= 1'b0;
            core_reset   <= 1'b0;
            words_loaded <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Bench for mips_boot_loader: header table, randomized payloads and valid gaps,
// reset mid-load and restart sequences, checked against a byte-stream model.
module tb_mips_boot_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imem_we, core_reset, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  mips_boot_loader #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] hdr;
    int          pct;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  wr_t         wr_q[$];
  logic [7:0]  stream[$];
  logic [31:0] pay[$];
  vec_t        vecs[8];
  int          checks = 0;
  int          failures = 0;

  always @(negedge clk) begin
    wr_t w;
    if (imem_we) begin
      w.addr = int'(imem_addr);
      w.data = imem_wdata;
      wr_q.push_back(w);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A header is accepted exactly when its whole 32-bit value is a count 1..capacity.
  function automatic bit hdr_ok(input logic [31:0] h);
    return (h >= 32'd1) && (h <= (32'd1 << AW));
  endfunction

  task automatic build(input logic [31:0] h);
    logic [31:0] w;
    stream.delete();
    for (int b = 0; b < 4; b++) stream.push_back(h[8*b +: 8]);
    if (hdr_ok(h)) begin
      for (int k = 0; k < int'(h); k++) begin
        w = pay[k];
        for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
      end
    end
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    repeat (n) pay.push_back($urandom);
  endtask

  task automatic send(input int pct, input int pulse_at);
    int i = 0;
    int guard = 0;
    while (i < stream.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      rx_data  = stream[i];
      rx_valid = ($urandom_range(0, 99) < pct);
      start    = (i == pulse_at);
      if (rx_valid && rx_ready) i++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    chk("bytes_accepted", i, stream.size());
  endtask

  task automatic pulse_start;
    @(negedge clk);
    wr_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_core_reset", core_reset, 0);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_words", words_loaded, 0);
    chk("start_busy", busy, 1);
  endtask

  task automatic finish_check(input logic [31:0] h);
    int n;
    n = hdr_ok(h) ? int'(h) : 0;
    if (n > 0) begin
      chk("last_write_we", imem_we, 1);
      chk("done_not_early", done, 0);
      chk("flush_ready", rx_ready, 0);
      @(negedge clk);
      chk("done", done, 1);
      chk("core_released", core_reset, 1);
      chk("words_loaded", words_loaded, n);
      chk("busy_idle", busy, 0);
      chk("no_error", error, 0);
    end else begin
      chk("err_flag", error, 1);
      chk("err_core_held", core_reset, 0);
      chk("err_ready", rx_ready, 0);
      chk("err_done", done, 0);
      repeat (3) @(negedge clk);
      chk("err_flag_held", error, 1);
    end
    chk("write_count", wr_q.size(), n);
    for (int k = 0; k < n && k < wr_q.size(); k++) begin
      chk("write_addr", wr_q[k].addr, k);
      chk("write_data", wr_q[k].data, pay[k]);
    end
  endtask

  task automatic run_load(input logic [31:0] h, input int pct, input int pulse_at);
    build(h);
    pulse_start();
    send(pct, pulse_at);
    finish_check(h);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_core_reset"}, core_reset, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_words"}, words_loaded, 0);
  endtask

  initial begin
    vecs[0] = '{32'd0,          100, 1'b1, 0};
    vecs[1] = '{32'd17,         100, 1'b1, 0};
    vecs[2] = '{32'd16,         100, 1'b0, 16};
    vecs[3] = '{32'd1,          100, 1'b0, 1};
    vecs[4] = '{32'h0000_0021,  100, 1'b1, 0};
    vecs[5] = '{32'h8000_0003,   50, 1'b1, 0};
    vecs[6] = '{32'd5,           50, 1'b0, 5};
    vecs[7] = '{32'd16,          50, 1'b0, 16};

    // Power-on reset
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    // Two-word load with continuous valid, then pending extra bytes
    pay.delete();
    pay.push_back(32'h2000_0005);
    pay.push_back(32'h0000_0000);
    run_load(32'd2, 100, -1);
    chk("first_word_literal", wr_q[0].data, 32'h2000_0005);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("extra_not_ready", rx_ready, 0);
    end
    rx_valid = 1'b0;
    chk("extra_no_write", wr_q.size(), 2);

    // Empty header, then recovery with a single word
    pay.delete();
    run_load(32'd0, 100, -1);
    rand_pay(1);
    run_load(32'd1, 100, -1);

    // Same two-word load with random valid gaps
    pay.delete();
    pay.push_back(32'h2000_0005);
    pay.push_back(32'h0000_0000);
    run_load(32'd2, 50, -1);

    // Header table, including capacity limits and nonzero upper bits
    for (int v = 0; v < 8; v++) begin
      rand_pay(vecs[v].exp_words);
      run_load(vecs[v].hdr, vecs[v].pct, -1);
      chk("vec_error", error, vecs[v].exp_err);
      chk("vec_words", words_loaded, vecs[v].exp_words);
    end

    // Reset after six payload bytes of a three-word load
    rand_pay(3);
    build(32'd3);
    pulse_start();
    while (stream.size() > 10) void'(stream.pop_back());
    send(100, -1);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    reset    = 1'b1;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midreset_ready", rx_ready, 0);
      chk("midreset_core_held", core_reset, 0);
    end
    rx_valid = 1'b0;
    chk("midreset_writes", wr_q.size(), 1);
    chk("midreset_word0", wr_q[0].data, pay[0]);
    run_load(32'd3, 100, -1);

    // Restart from DONE, with a stray start pulse in the middle of LOAD
    rand_pay(4);
    run_load(32'd4, 100, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
